// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receive-path parameters and types.
// Used by the cyclic-prefix strip stage and its bus interface.
package ofdm_rx_pkg;
  localparam int sample_bit_width_c  = 12;
  localparam int symbol_length_c     = 320;
  localparam int raw_symbol_length_c = 256;
  localparam int cp_len              = symbol_length_c - raw_symbol_length_c;
  localparam int off_w               = $clog2(cp_len);
  localparam int cnt_w               = 9;

  typedef enum logic [1:0] {IDLE, SKIP, DATA, TAIL} cp_state_t;

  // Keep the FFT window inside the prefix even if the offset field is wider than cp_len needs.
  function automatic logic [off_w-1:0] clamp_off(input logic [off_w-1:0] o);
    return (int'({1'b0, o}) >= cp_len) ? off_w'(cp_len - 1) : o;
  endfunction
endpackage

// File: rtl/ofdm_cp_strip_if.sv
// Sample-stream bus of the CP strip stage: time-aligned input in, raw FFT samples out.
interface ofdm_cp_strip_if;
  import ofdm_rx_pkg::*;
  logic signed [sample_bit_width_c-1:0] in_i, in_q;
  logic                                 in_valid;
  logic                                 sym_start;
  logic [off_w-1:0]                     fine_offset;
  logic signed [sample_bit_width_c-1:0] out_i, out_q;
  logic                                 out_valid;
  logic                                 out_start;
  logic                                 out_last;
  logic                                 resync_err;

  modport master (output in_i, in_q, in_valid, sym_start, fine_offset,
                  input  out_i, out_q, out_valid, out_start, out_last, resync_err);
  modport slave  (input  in_i, in_q, in_valid, sym_start, fine_offset,
                  output out_i, out_q, out_valid, out_start, out_last, resync_err);
endinterface

// File: rtl/ofdm_cp_strip.sv
// Cyclic-prefix removal: drops the prefix (less fine_offset), forwards 256 raw samples,
// drops the off_q-sample tail. Outputs are registered one cycle behind the input.
module ofdm_cp_strip
  import ofdm_rx_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             sys_init,
  ofdm_cp_strip_if.slave   bus
);
  cp_state_t        state_q, state_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [off_w-1:0] off_q, off_d, new_off;
  logic [cnt_w-1:0] skip_last, tail_last;
  logic             fwd, err;

  logic signed [sample_bit_width_c-1:0] oi_q, oq_q;
  logic             ov_q, os_q, ol_q, re_q;

  assign new_off   = clamp_off(bus.fine_offset);
  // Counter index of the final dropped sample in each discard phase.
  assign skip_last = cnt_w'(cp_len - 1) - cnt_w'(off_q);
  assign tail_last = cnt_w'(off_q) - cnt_w'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    fwd     = 1'b0;
    err     = 1'b0;
    if (bus.in_valid) begin
      if (bus.sym_start) begin
        // A start sample is always SKIP sample 0, even when it aborts a symbol.
        err   = (state_q != IDLE);
        off_d = new_off;
        if (new_off == off_w'(cp_len - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          state_d = SKIP;
          cnt_d   = cnt_w'(1);
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          SKIP: begin
            if (cnt_q == skip_last) begin
              state_d = DATA;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
          end
          DATA: begin
            fwd = 1'b1;
            if (cnt_q == cnt_w'(raw_symbol_length_c - 1)) begin
              state_d = (off_q != '0) ? TAIL : IDLE;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
          end
          TAIL: begin
            if (cnt_q == tail_last) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      oi_q    <= '0;
      oq_q    <= '0;
      ov_q    <= 1'b0;
      os_q    <= 1'b0;
      ol_q    <= 1'b0;
      re_q    <= 1'b0;
    end else if (sys_init) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      oi_q    <= '0;
      oq_q    <= '0;
      ov_q    <= 1'b0;
      os_q    <= 1'b0;
      ol_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      ov_q    <= fwd;
      os_q    <= fwd && (cnt_q == '0);
      ol_q    <= fwd && (cnt_q == cnt_w'(raw_symbol_length_c - 1));
      re_q    <= err;
      if (fwd) begin
        oi_q <= bus.in_i;
        oq_q <= bus.in_q;
      end
    end
  end

  assign bus.out_i      = oi_q;
  assign bus.out_q      = oq_q;
  assign bus.out_valid  = ov_q;
  assign bus.out_start  = os_q;
  assign bus.out_last   = ol_q;
  assign bus.resync_err = re_q;
endmodule

// File: tb/tb_ofdm_cp_strip.sv
// Self-checking bench for ofdm_cp_strip: table of offset/gap cases plus resync and reset sequences.
module tb_ofdm_cp_strip;
  import ofdm_rx_pkg::*;

  logic sys_clk = 1'b0, sys_rstn = 1'b0, sys_init = 1'b0;
  always #5 sys_clk = ~sys_clk;

  ofdm_cp_strip_if bus ();
  ofdm_cp_strip dut (.sys_clk(sys_clk), .sys_rstn(sys_rstn), .sys_init(sys_init), .bus(bus));

  typedef struct {
    logic [11:0] i, q;
    logic        st, last;
  } exp_t;

  typedef struct {
    logic [5:0] off;
    int         first;
    bit         gaps;
    int         nsym;
  } case_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, n_out = 0, rs_cnt = 0;

  function automatic logic [11:0] enc_i(input int tag, input int n);
    logic [11:0] v;
    v = {3'(tag), 9'(n)};
    return v;
  endfunction

  // Output monitor / scoreboard.
  always @(negedge sys_clk) begin
    exp_t e;
    if (bus.resync_err) rs_cnt++;
    if (bus.out_valid) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out i=%h q=%h start=%b last=%b", bus.out_i, bus.out_q,
                 bus.out_start, bus.out_last);
      end else begin
        e = sb.pop_front();
        if (bus.out_i !== e.i || bus.out_q !== e.q || bus.out_start !== e.st ||
            bus.out_last !== e.last) begin
          errors++;
          $display("FAIL out_sample got i=%h q=%h s=%b l=%b want i=%h q=%h s=%b l=%b",
                   bus.out_i, bus.out_q, bus.out_start, bus.out_last, e.i, e.q, e.st, e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_valid    = 1'b0;
    bus.sym_start   = 1'b0;
    bus.in_i        = '0;
    bus.in_q        = '0;
    bus.fine_offset = '0;
  endtask

  // One valid sample; idle cycles before it carry random start/offset that must be ignored.
  task automatic send(input int tag, input int n, input logic st, input logic [5:0] off,
                      input bit gaps);
    logic [11:0] v;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        @(negedge sys_clk);
        bus.in_valid    = 1'b0;
        bus.sym_start   = 1'($urandom_range(0, 1));
        bus.fine_offset = 6'($urandom_range(0, 63));
      end
    end
    @(negedge sys_clk);
    v = enc_i(tag, n);
    bus.in_valid    = 1'b1;
    bus.sym_start   = st;
    bus.in_i        = v;
    bus.in_q        = ~v;
    bus.fine_offset = st ? off : 6'($urandom_range(0, 63));
  endtask

  task automatic push_exp(input int tag, input int n, input logic st, input logic last);
    exp_t e;
    e.i = enc_i(tag, n);
    e.q = ~e.i;
    e.st = st;
    e.last = last;
    sb.push_back(e);
  endtask

  // Whole 320-sample symbol; window [first, first+255] is expected out.
  task automatic run_symbol(input int tag, input logic [5:0] off, input int first, input bit gaps);
    for (int n = 0; n < symbol_length_c; n++) begin
      if (n >= first && n < first + raw_symbol_length_c)
        push_exp(tag, n, n == first, n == first + raw_symbol_length_c - 1);
      send(tag, n, n == 0, off, gaps);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge sys_clk);
    idle_in();
    repeat (3) @(negedge sys_clk);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_start"}, int'(bus.out_start), 0);
    chk({tag, "_last"},  int'(bus.out_last), 0);
    chk({tag, "_err"},   int'(bus.resync_err), 0);
    chk({tag, "_i"},     int'(bus.out_i), 0);
    chk({tag, "_q"},     int'(bus.out_q), 0);
  endtask

  // Advance into DATA at cnt=50 (offset 0), leaving sample 114 pending.
  task automatic to_data50(input int tag);
    for (int n = 0; n < 114; n++) begin
      if (n >= 64) push_exp(tag, n, n == 64, 1'b0);
      send(tag, n, n == 0, 6'd0, 1'b0);
    end
    @(negedge sys_clk);
    bus.in_valid = 1'b1;
    bus.sym_start = 1'b0;
    bus.in_i = enc_i(tag, 114);
    bus.in_q = ~enc_i(tag, 114);
  endtask

  case_t cases[5];

  initial begin
    int o0, r0;
    cases[0] = '{off: 6'd0,  first: 64, gaps: 1'b0, nsym: 1};
    cases[1] = '{off: 6'd10, first: 54, gaps: 1'b0, nsym: 2};
    cases[2] = '{off: 6'd63, first: 1,  gaps: 1'b0, nsym: 1};
    cases[3] = '{off: 6'd0,  first: 64, gaps: 1'b1, nsym: 1};
    cases[4] = '{off: 6'd10, first: 54, gaps: 1'b1, nsym: 1};

    idle_in();
    repeat (2) @(posedge sys_clk);
    #1 chk_zero("reset");
    @(negedge sys_clk);
    sys_rstn = 1'b1;

    for (int c = 0; c < 5; c++) begin
      o0 = n_out;
      r0 = rs_cnt;
      for (int s = 0; s < cases[c].nsym; s++)
        run_symbol(c + s, cases[c].off, cases[c].first, cases[c].gaps);
      drain($sformatf("case%0d_left", c));
      chk($sformatf("case%0d_count", c), n_out - o0, raw_symbol_length_c * cases[c].nsym);
      chk($sformatf("case%0d_resync", c), rs_cnt - r0, 0);
    end

    // Restart at DATA cnt=100: truncated symbol, one error pulse, full second symbol.
    o0 = n_out;
    r0 = rs_cnt;
    for (int n = 0; n < 164; n++) begin
      if (n >= 64) push_exp(6, n, n == 64, 1'b0);
      send(6, n, n == 0, 6'd0, 1'b0);
    end
    run_symbol(7, 6'd0, 64, 1'b0);
    drain("resync_left");
    chk("resync_count", n_out - o0, 100 + raw_symbol_length_c);
    chk("resync_err", rs_cnt - r0, 1);

    // Asynchronous reset mid-DATA.
    to_data50(1);
    #2 sys_rstn = 1'b0;
    #1 chk_zero("rst_mid");
    chk("rst_left", sb.size(), 0);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    o0 = n_out;
    for (int n = 0; n < 40; n++) send(2, n, 1'b0, 6'd0, 1'b0);
    drain("rst_after_left");
    chk("rst_no_out", n_out - o0, 0);

    // Synchronous init mid-DATA, with a valid sample in the same cycle.
    to_data50(3);
    sys_init = 1'b1;
    @(posedge sys_clk);
    #1 chk_zero("init_mid");
    chk("init_left", sb.size(), 0);
    @(negedge sys_clk);
    sys_init = 1'b0;
    o0 = n_out;
    for (int n = 0; n < 40; n++) send(4, n, 1'b0, 6'd0, 1'b0);
    drain("init_after_left");
    chk("init_no_out", n_out - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofdm_cp_strip.md
# ofdm_cp_strip

Cyclic-prefix removal stage of the OFDM receive path. It takes the time-aligned baseband sample stream (I/Q, one sample per valid) together with a symbol-start strobe from the synchronisation stage. For each 320-sample OFDM symbol it discards the cyclic prefix, forwards exactly 256 raw samples to the FFT stage with start/last markers, and drops the remaining tail. A fine timing offset lets the FFT window sit inside the prefix to tolerate ISI.

## Interface
- sample_bit_width_c, 12, width of each signed I and Q sample
- symbol_length_c, 320, samples per OFDM symbol including cyclic prefix
- raw_symbol_length_c, 256, samples per symbol forwarded to the FFT
- Derived: cp_len = symbol_length_c - raw_symbol_length_c (64); off_w = $clog2(cp_len) (6)

Ports:
- sys_clk  in  1  single system clock, all logic on rising edge
- sys_rstn  in  1  asynchronous, active-low reset
- sys_init  in  1  synchronous clear; same effect as reset, applied at the clock edge
- in_i, in_q  in  sample_bit_width_c  signed input sample
- in_valid  in  1  input sample qualifier
- sym_start  in  1  marks the current valid sample as sample 0 of a symbol; ignored when in_valid=0
- fine_offset  in  off_w  window advance into the CP, 0..cp_len-1; sampled only on an accepted sym_start
- out_i, out_q  out  sample_bit_width_c  raw symbol sample
- out_valid  out  1  output qualifier
- out_start  out  1  first raw sample of a symbol (with out_valid)
- out_last  out  1  sample raw_symbol_length_c-1 (with out_valid)
- resync_err  out  1  one-cycle pulse: sym_start arrived while a symbol was in progress

## Operation
- States: IDLE, SKIP, DATA, TAIL. One sample counter cnt (9 bits), plus a latched offset off_q.
- IDLE: accepted sym_start -> latch off_q = fine_offset. That sample is SKIP sample 0. Set cnt = 1 and enter SKIP. If cp_len - off_q = 1, go straight to DATA with cnt = 0.
- SKIP: drop each valid sample. After cp_len - off_q samples including the start sample, enter DATA with cnt = 0.
- DATA: forward each valid sample. out_start is set when cnt = 0 and out_last when cnt = raw_symbol_length_c-1. After the last sample, go to TAIL if off_q > 0, otherwise to IDLE.
- TAIL: drop off_q samples, then go to IDLE.
- Total samples consumed per symbol is always symbol_length_c.
- sym_start with in_valid in SKIP, DATA or TAIL:
  - Pulse resync_err.
  - Abort the current symbol; no out_last is issued for a truncated symbol.
  - Restart as in IDLE using that sample and the new fine_offset.
- sym_start in IDLE on the same sample as a TAIL/DATA completion: handled as a new start, not an error. A start coinciding with the final TAIL sample counts as an error (symbol still in progress).
- fine_offset values >= cp_len are clamped to cp_len-1.
- in_valid gaps: the counter and state freeze; no output.
- Sample arithmetic: pass-through, no width change.

## Timing
- Latency: one cycle from accepted input to out_valid, with out_i/out_q/out_start/out_last registered together.
- out_valid, out_start, out_last and resync_err are one-cycle pulses per sample. out_i/out_q hold their last value when out_valid=0.
- Reset / sys_init values:
  - state IDLE, cnt 0, off_q 0
  - out_i, out_q 0
  - out_valid, out_start, out_last, resync_err 0
- Reset mid-symbol: the output stream stops immediately (out_valid 0 from the reset edge); the next symbol needs a new sym_start.
- sys_init takes priority over in_valid/sym_start in the same cycle.
- No backpressure: the downstream stage must accept one sample per cycle.

## Structure
- Shared package ofdm_rx_pkg: sample_bit_width_c, symbol_length_c, raw_symbol_length_c, derived cp_len, off_w, and the state enum cp_state_t {IDLE, SKIP, DATA, TAIL}.
- Single module, no sub-module. The FSM and counter are small enough to keep inline.

## Test plan
- Offset 0, continuous valid, sym_start on sample 0: samples 64..319 emerge one cycle later. out_start is on sample 64, out_last on sample 319, and exactly 256 outputs appear.
- Offset 10, samples numbered n: outputs are n = 54..309 and samples 310..319 are dropped. Back-to-back symbols with sym_start at sample 320 produce no resync_err and a contiguous second window.
- Random in_valid gaps (50% duty): the same 256-sample window as the gapless case, with order preserved.
- sym_start repeated at DATA cnt=100: resync_err pulses once, no out_last for the first symbol, and a full 256-sample second symbol follows.
- sys_rstn low, and separately sys_init, at DATA cnt=50: all outputs 0 next cycle. Later input with no sym_start produces no output.
- fine_offset=63 (cp_len-1): SKIP drops 1 sample (DATA entered directly), samples 1..256 are output, and 63 tail samples are dropped.
